// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared definitions for the immediate encoder and the
//               immediate generator. Holds the immediate-format codes, the
//               raw-field width and a sign-extension helper used by the
//               representability checks.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Immediate-format codes, shared with the immediate generator.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // Width of instr[31:7], the part of the instruction that carries
    // immediate bits.
    localparam int unsigned C_RAW_W = 25;

    // The error counter saturates at this value.
    localparam logic [7:0] C_ERR_MAX = 8'hFF;

    // True when v[31:lsb] are all equal. That is the condition for v to
    // survive truncation to lsb+1 bits followed by sign extension.
    function automatic logic all_same(input logic [31:0] v, input logic [4:0] lsb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << lsb;
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_scatter.sv
`default_nettype none
// ============================================================================
// Module      : imm_scatter
// Description : Combinational core of the immediate encoder. Scatters a
//               32-bit immediate into the raw field instr[31:7] for the
//               selected format. Raw bits that the format does not own are
//               taken from base_raw. It also reports whether the immediate
//               can be represented in that format.
// Ports       : immediate  [31:0] in  - value to encode
//               imm_source [2:0]  in  - format code (imm_src_e)
//               base_raw   [24:0] in  - base_instr[31:7]
//               raw        [24:0] out - encoded instr[31:7]
//               err               out - immediate not representable
// Revision    : 1.0 - initial release
// ============================================================================
module imm_scatter
    import imm_pkg::*;
(
    input  logic [31:0]        immediate,
    input  logic [2:0]         imm_source,
    input  logic [C_RAW_W-1:0] base_raw,
    output logic [C_RAW_W-1:0] raw,
    output logic               err
);

    always_comb begin
        raw = base_raw;
        err = 1'b0;
        case (imm_source)
            IMM_I: begin
                raw[24:13] = immediate[11:0];
                err        = !all_same(immediate, 5'd11);
            end
            IMM_S: begin
                raw[24:18] = immediate[11:5];
                raw[4:0]   = immediate[4:0];
                err        = !all_same(immediate, 5'd11);
            end
            IMM_B: begin
                // Bit 0 is implied zero by the decoder, so an odd value
                // cannot be encoded.
                raw[24]    = immediate[12];
                raw[0]     = immediate[11];
                raw[23:18] = immediate[10:5];
                raw[4:1]   = immediate[4:1];
                err        = !all_same(immediate, 5'd12) || immediate[0];
            end
            IMM_J: begin
                raw[24]    = immediate[20];
                raw[12:5]  = immediate[19:12];
                raw[13]    = immediate[11];
                raw[23:14] = immediate[10:1];
                err        = !all_same(immediate, 5'd20) || immediate[0];
            end
            IMM_U: begin
                raw[24:5]  = immediate[31:12];
                err        = (immediate[11:0] != 12'h000);
            end
            default: begin
                // Unknown format: pass the base instruction through untouched.
                err = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Two-stage valid/ready pipeline that encodes an immediate
//               into a base instruction. This is the inverse of the immediate
//               generator. Stage 1 scatters the immediate and registers the
//               raw field and the range flag. Stage 2 registers the merged
//               instruction. A saturating counter counts the errored beats
//               that are delivered downstream.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid / in_ready  - request handshake
//               imm_source [2:0]     - format code
//               immediate  [31:0]    - value to encode
//               base_instr [31:0]    - opcode/register/funct bits
//               out_valid / out_ready- result handshake
//               instr      [31:0]    - encoded instruction
//               range_err            - immediate not representable
//               err_count  [7:0]     - saturating errored-beat count
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
    import imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_source,
    input  logic [31:0] immediate,
    input  logic [31:0] base_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        range_err,
    output logic [7:0]  err_count
);

    // ------------------------------------------------------------------
    // Stage 1 combinational encode
    // ------------------------------------------------------------------
    logic [C_RAW_W-1:0] w_raw;
    logic               w_err;

    imm_scatter u_scatter (
        .immediate  (immediate),
        .imm_source (imm_source),
        .base_raw   (base_instr[31:7]),
        .raw        (w_raw),
        .err        (w_err)
    );

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic               r_s1_valid;
    logic [C_RAW_W-1:0] r_s1_raw;
    logic [6:0]         r_s1_low;
    logic               r_s1_err;

    logic               r_out_valid;
    logic [31:0]        r_instr;
    logic               r_range_err;
    logic [7:0]         r_err_count;

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic w_out_fire;
    logic w_s2_load;
    logic w_s1_adv;
    logic w_in_ready;
    logic w_in_fire;

    assign w_out_fire = r_out_valid && out_ready;
    // Stage 2 can take a new beat when it is empty or its beat leaves now.
    assign w_s2_load  = !r_out_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_load;
    // This path is combinational from out_ready. With no skid buffer,
    // stage 1 can only accept while its own beat moves on.
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign w_in_fire  = in_valid && w_in_ready;

    // Control and output registers (reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_instr     <= 32'h0;
            r_range_err <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_out_valid <= r_s1_valid;
            end

            if (w_s1_adv) begin
                r_instr     <= {r_s1_raw, r_s1_low};
                r_range_err <= r_s1_err;
            end

            if (w_out_fire && r_range_err && (r_err_count != C_ERR_MAX)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Stage 1 data registers. These are qualified by r_s1_valid and need
    // no reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_raw <= w_raw;
            r_s1_low <= base_instr[6:0];
            r_s1_err <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign instr     = r_instr;
    assign range_err = r_range_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_encoder
// Description : Self-checking bench for imm_encoder. A scoreboard queue
//               holds the expected beats. They are computed from the
//               instruction-format layouts and from the numeric ranges of
//               each format. Delivered beats are also decoded with a
//               standard immediate generator to confirm the round trip.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_source;
    logic [31:0] immediate;
    logic [31:0] base_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        range_err;
    logic [7:0]  err_count;

    imm_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm_source (imm_source),
        .immediate  (immediate),
        .base_instr (base_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .range_err  (range_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_cnt  = 0;
    logic        in_fired;
    logic        last_in_ready;
    logic        hold_chk = 1'b0;
    logic [31:0] held_instr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference encoding, taken from the architectural instruction layouts.
    function automatic exp_t model(input logic [2:0] src, input logic [31:0] imm,
                                   input logic [31:0] base);
        exp_t e;
        int   v;
        v      = $signed(imm);
        e.src  = src;
        e.imm  = imm;
        e.base = base;
        case (src)
            3'd0: begin
                e.instr = {imm[11:0], base[19:0]};
                e.err   = !(v >= -2048 && v <= 2047);
            end
            3'd1: begin
                e.instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                e.err   = !(v >= -2048 && v <= 2047);
            end
            3'd2: begin
                e.instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                e.err   = !(v >= -4096 && v <= 4095 && (v % 2) == 0);
            end
            3'd3: begin
                e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                e.err   = !(v >= -1048576 && v <= 1048575 && (v % 2) == 0);
            end
            3'd4: begin
                e.instr = {imm[31:12], base[11:0]};
                e.err   = (imm % 32'd4096) != 32'd0;
            end
            default: begin
                e.instr = base;
                e.err   = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Standard immediate generator (decoder side).
    function automatic logic [31:0] immgen(input logic [31:0] i, input logic [2:0] src);
        case (src)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'h000};
        endcase
    endfunction

    // Instruction bits that carry immediate data for each format.
    function automatic logic [31:0] owned_mask(input logic [2:0] src);
        case (src)
            3'd0:       return 32'hFFF0_0000;
            3'd1, 3'd2: return 32'hFE00_0F80;
            default:    return 32'hFFFF_F000;
        endcase
    endfunction

    // One clock cycle: sample at the falling edge, then return 1 time unit
    // after the next rising edge so that new inputs can be driven.
    task automatic step();
        exp_t        e;
        logic [31:0] m;
        @(negedge clk);
        in_fired      = 1'b0;
        last_in_ready = in_ready;
        if (rst) begin
            exp_q.delete();
            exp_cnt  = 0;
            hold_chk = 1'b0;
        end else begin
            check_eq("err_count", {24'h0, err_count}, exp_cnt);
            if (hold_chk) begin
                check_eq("stall_valid", {31'h0, out_valid}, 32'd1);
                check_eq("stall_instr", instr, held_instr);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(imm_source, immediate, base_instr));
                in_fired = 1'b1;
            end
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", {31'h0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("instr", instr, e.instr);
                    check_eq("range_err", {31'h0, range_err}, {31'h0, e.err});
                    if (!e.err) begin
                        m = owned_mask(e.src);
                        check_eq("roundtrip", immgen(instr, e.src), e.imm);
                        check_eq("passthru", instr & ~m, e.base & ~m);
                    end
                    if (e.err && exp_cnt < 255) exp_cnt++;
                end
            end
            hold_chk   = out_valid && !out_ready;
            held_instr = instr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
        check_eq("drain", exp_q.size(), 32'd0);
    endtask

    // Single beat with out_ready high. Checks the 2-cycle latency and the
    // expected output values.
    task automatic send_one(input logic [2:0] src, input logic [31:0] imm,
                            input logic [31:0] base, input logic [31:0] exp_instr,
                            input logic exp_err);
        imm_source = src;
        immediate  = imm;
        base_instr = base;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        step();
        check_eq("accepted", {31'h0, in_fired}, 32'd1);
        in_valid = 1'b0;
        check_eq("lat1_valid", {31'h0, out_valid}, 32'd0);
        step();
        check_eq("lat2_valid", {31'h0, out_valid}, 32'd1);
        check_eq("dir_instr", instr, exp_instr);
        check_eq("dir_err", {31'h0, range_err}, {31'h0, exp_err});
        step();
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       r = {{19{r[12]}}, r[12:0]};
            1:       r = {{11{r[20]}}, r[20:0]};
            2:       r = {r[31:12], 12'h000};
            3:       r = {{21{r[11]}}, r[10:0]};
            default: ;
        endcase
        if ($urandom_range(0, 1) == 0) r[0] = 1'b0;
        return r;
    endfunction

    initial begin
        logic [31:0] bp_imm[4];
        int          idx;
        int          sent;
        int          cnt0;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        imm_source = 3'd0;
        immediate  = 32'h0;
        base_instr = 32'h0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_range_err", {31'h0, range_err}, 32'd0);
        check_eq("rst_err_count", {24'h0, err_count}, 32'd0);
        check_eq("rst_in_ready", {31'h0, in_ready}, 32'd1);

        // Directed beats
        send_one(3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
        send_one(3'd2, 32'h0000_0FFE, 32'h0000_0063, model(3'd2, 32'h0000_0FFE, 32'h63).instr, 1'b0);
        check_eq("b_decode", immgen(instr, 3'd2), 32'h0000_0FFE);
        cnt0 = err_count;
        send_one(3'd2, 32'h0000_0003, 32'h0000_0063, model(3'd2, 32'h3, 32'h63).instr, 1'b1);
        step();
        check_eq("b_err_inc", {24'h0, err_count}, cnt0 + 1);
        send_one(3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        send_one(3'd4, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1);

        // Back-pressure: 4 J beats, downstream stalled for 3 cycles
        bp_imm = '{32'h0000_0002, 32'hFFF0_0000, 32'h000F_FFFE, 32'h0001_2344};
        idx = 0;
        base_instr = 32'h0000_056F;
        imm_source = 3'd3;
        for (int cyc = 0; cyc < 30 && (idx < 4 || exp_q.size() > 0); cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (idx < 4);
            immediate = (idx < 4) ? bp_imm[idx] : 32'h0;
            step();
            if (in_fired) idx++;
            if (cyc == 1) check_eq("bp_ready_c1", {31'h0, last_in_ready}, 32'd1);
            if (cyc == 2) check_eq("bp_ready_full", {31'h0, last_in_ready}, 32'd0);
        end
        check_eq("bp_all_sent", idx, 32'd4);
        drain();

        // Random round trip with random handshakes
        sent = 0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
            if (in_fired || !in_valid) begin
                in_valid   = ($urandom_range(0, 4) != 0);
                imm_source = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 4))
                                                         : 3'($urandom_range(5, 7));
                immediate  = rand_imm();
                base_instr = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (in_fired) sent++;
        end
        check_eq("rand_sent", sent, 32'd10000);
        drain();

        // Saturation: 300 invalid-code beats
        imm_source = 3'd7;
        base_instr = 32'hDEAD_BEEF;
        immediate  = 32'h0;
        out_ready  = 1'b1;
        sent = 0;
        for (int cyc = 0; cyc < 1000 && sent < 300; cyc++) begin
            in_valid = 1'b1;
            step();
            if (in_fired) sent++;
        end
        drain();
        step();
        check_eq("sat_count", {24'h0, err_count}, 32'd255);

        // Reset with 2 beats in flight
        out_ready  = 1'b0;
        imm_source = 3'd6;
        in_valid   = 1'b1;
        step();
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_valid", {31'h0, out_valid}, 32'd0);
        check_eq("mid_rst_count", {24'h0, err_count}, 32'd0);
        check_eq("mid_rst_ready", {31'h0, in_ready}, 32'd1);
        step();
        step();
        check_eq("post_rst_valid", {31'h0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
